// File: rtl/movwide_pkg.sv
// Shared types and constants for the LEGv8 move-wide execution unit.
package movwide_pkg;

    typedef enum logic [1:0] {
        MW_MOVZ = 2'b00,
        MW_MOVN = 2'b01,
        MW_MOVK = 2'b10,
        MW_RSVD = 2'b11
    } mw_op_e;

    localparam int unsigned XZR_IDX = 31;
    localparam int unsigned IMM_W   = 16;

    // Number of 16-bit lanes in a datapath of the given width.
    function automatic int unsigned lane_count(input int unsigned data_w);
        return data_w / IMM_W;
    endfunction

endpackage

// File: rtl/movwide_lane_merge.sv
// Combinational MOVZ/MOVN/MOVK lane merge: decodes the halfword select and
// muxes each 16-bit lane between imm16, zero and the incoming Db lane.
module movwide_lane_merge
    import movwide_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned HW_W   = $clog2(DATA_W / 16)
) (
    input  logic [1:0]        op,
    input  logic [IMM_W-1:0]  imm16,
    input  logic [HW_W-1:0]   hw,
    input  logic [DATA_W-1:0] db,
    output logic [DATA_W-1:0] data,
    output logic              err
);

    localparam int unsigned NUM_LANES = lane_count(DATA_W);

    mw_op_e               op_e;
    logic [NUM_LANES-1:0] lane_sel;
    logic [DATA_W-1:0]    merged;
    logic                 op_bad;

    assign op_e   = mw_op_e'(op);
    assign op_bad = (op_e == MW_RSVD);

    // An out-of-range hw leaves every lane unselected, which flags the error.
    always_comb begin
        lane_sel = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (32'(hw) == k) begin
                lane_sel[k] = 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [IMM_W-1:0] db_lane;
        logic [IMM_W-1:0] zero_lane;
        logic [IMM_W-1:0] lane_out;

        assign db_lane   = db[k*IMM_W +: IMM_W];
        assign zero_lane = lane_sel[k] ? imm16 : '0;

        always_comb begin
            lane_out = '0;
            case (op_e)
                MW_MOVZ: lane_out = zero_lane;
                MW_MOVN: lane_out = ~zero_lane;
                MW_MOVK: lane_out = lane_sel[k] ? imm16 : db_lane;
                default: lane_out = '0;
            endcase
        end

        assign merged[k*IMM_W +: IMM_W] = lane_out;
    end

    assign err  = op_bad | ~(|lane_sel);
    assign data = err ? '0 : merged;

endmodule

// File: rtl/movwide_pipe.sv
// Two-stage move-wide execute unit with valid/ready on both sides and
// S2-to-S1 forwarding so back-to-back MOVK chains see the newest rd value.
module movwide_pipe
    import movwide_pkg::*;
#(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned HW_W       = $clog2(DATA_W / 16)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [IMM_W-1:0]      in_imm16,
    input  logic [HW_W-1:0]       in_hw,
    input  logic [DATA_W-1:0]     in_db,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_err
);

    localparam logic [REG_ADDR_W-1:0] XZR = REG_ADDR_W'(XZR_IDX);

    logic                  s1_valid_q;
    logic [1:0]            s1_op_q;
    logic [REG_ADDR_W-1:0] s1_rd_q;
    logic [IMM_W-1:0]      s1_imm_q;
    logic [HW_W-1:0]       s1_hw_q;
    logic [DATA_W-1:0]     s1_db_q;

    logic                  s2_valid_q;
    logic [REG_ADDR_W-1:0] s2_rd_q;
    logic [DATA_W-1:0]     s2_data_q;
    logic                  s2_err_q;

    logic                  s2_adv;
    logic                  fwd_cap;
    logic                  fwd_cmp;
    logic [DATA_W-1:0]     eff_db;
    logic [DATA_W-1:0]     merge_data;
    logic                  merge_err;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;

    // S2 holds the newest not-yet-visible write; an erred entry never writes data.
    assign fwd_cap = s2_valid_q && !s2_err_q && (s2_rd_q == in_rd) && (in_rd != XZR);
    assign fwd_cmp = s2_valid_q && !s2_err_q && (s2_rd_q == s1_rd_q) && (s1_rd_q != XZR);
    assign eff_db  = fwd_cmp ? s2_data_q : s1_db_q;

    movwide_lane_merge #(
        .DATA_W (DATA_W),
        .HW_W   (HW_W)
    ) u_lane_merge (
        .op    (s1_op_q),
        .imm16 (s1_imm_q),
        .hw    (s1_hw_q),
        .db    (eff_db),
        .data  (merge_data),
        .err   (merge_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_rd_q    <= '0;
            s1_imm_q   <= '0;
            s1_hw_q    <= '0;
            s1_db_q    <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_op_q  <= in_op;
                s1_rd_q  <= in_rd;
                s1_imm_q <= in_imm16;
                s1_hw_q  <= in_hw;
                s1_db_q  <= fwd_cap ? s2_data_q : in_db;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_rd_q    <= '0;
            s2_data_q  <= '0;
            s2_err_q   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_rd_q   <= s1_rd_q;
                s2_data_q <= merge_data;
                s2_err_q  <= merge_err;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_rd    = s2_rd_q;
    assign out_data  = s2_data_q;
    assign out_err   = s2_err_q;

endmodule
